sc_computer_top: RTL and testbench

- Single-cycle MIPS-subset computer: CPU, program ROM, data RAM and a memory-mapped I/O block.
- A fixed built-in program loops forever:
  - reads in_port0 and in_port1;
  - writes both values to out_port0 and out_port1;
  - writes their sum to out_port2.
- Each output port is shown as a two-digit decimal number on a pair of active-low 7-segment displays.
- This is the top-level board block: switches feed the inputs, HEX displays show the outputs.

---
 rtl/sc_computer_pkg.sv | 60 ++++++
 rtl/dec2seg.sv | 27 ++
 rtl/sc_computer.sv | 233 +++++++++++++++++++++++
 tb/tb_sc_computer_top.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sc_computer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sc_computer_pkg
// Description : Shared opcode/funct encodings, I/O addresses, ALU operation
//               type and the 7-segment digit table for sc_computer_top.
// Revision    : 1.0  initial release
// ============================================================================
package sc_computer_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] c_FN_ADD = 6'b100000;
    localparam logic [5:0] c_FN_SUB = 6'b100010;
    localparam logic [5:0] c_FN_AND = 6'b100100;
    localparam logic [5:0] c_FN_OR  = 6'b100101;
    localparam logic [5:0] c_FN_SLT = 6'b101010;

    // Memory-mapped I/O byte addresses (only addr[7:2] is decoded)
    localparam logic [7:0] c_IO_IN0  = 8'h80;
    localparam logic [7:0] c_IO_IN1  = 8'h84;
    localparam logic [7:0] c_IO_OUT0 = 8'h80;
    localparam logic [7:0] c_IO_OUT1 = 8'h84;
    localparam logic [7:0] c_IO_OUT2 = 8'h88;

    // Active-low segments, bit6..bit0 = g..a; entry 0 is the rightmost group
    localparam logic [9:0][6:0] c_SEG_TABLE = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        return (d < 4'd10) ? c_SEG_TABLE[d] : 7'b1111111;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dec2seg.sv
`default_nettype none
// ============================================================================
// Module      : dec2seg
// Description : Shows a 32-bit unsigned value mod 100 as two active-low
//               7-segment digit codes (tens, ones).
// Revision    : 1.0  initial release
// ============================================================================
module dec2seg (
    input  logic [31:0] i_value,
    output logic [6:0]  o_tens,
    output logic [6:0]  o_ones
);
    import sc_computer_pkg::*;

    logic [6:0] w_mod;
    logic [3:0] w_tens;
    logic [3:0] w_ones;

    assign w_mod  = 7'(i_value % 32'd100);
    assign w_tens = 4'(w_mod / 7'd10);
    assign w_ones = 4'(w_mod % 7'd10);

    assign o_tens = seg_digit(w_tens);
    assign o_ones = seg_digit(w_ones);

endmodule
`default_nettype wire

// File: rtl/sc_computer.sv
`default_nettype none
// ============================================================================
// Module      : sc_computer_top
// Description : Single-cycle MIPS-subset computer with built-in I/O copy/add
//               program, data RAM, memory-mapped ports and 7-segment output.
// Revision    : 1.0  initial release
// ============================================================================
module sc_computer_top
    import sc_computer_pkg::*;
#(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 32
) (
    input  logic        mem_clk,
    input  logic        resetn,
    input  logic [31:0] in_port0,
    input  logic [31:0] in_port1,
    output logic [31:0] out_port0,
    output logic [31:0] out_port1,
    output logic [31:0] out_port2,
    output logic [6:0]  hex5,
    output logic [6:0]  hex4,
    output logic [6:0]  hex3,
    output logic [6:0]  hex2,
    output logic [6:0]  hex1,
    output logic [6:0]  hex0
);
    localparam int c_IMEM_AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam int c_DMEM_AW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

    logic [31:0] r_pc;
    logic [31:0] r_gpr  [32];
    logic [31:0] r_dmem [DMEM_WORDS];
    logic [31:0] r_out0;
    logic [31:0] r_out1;
    logic [31:0] r_out2;

    logic [c_IMEM_AW-1:0] w_iaddr;
    logic [31:0]          w_instr;
    logic [5:0]           w_opcode;
    logic [4:0]           w_rs;
    logic [4:0]           w_rt;
    logic [4:0]           w_rd;
    logic [5:0]           w_funct;
    logic [25:0]          w_target;
    logic [31:0]          w_imm_sext;
    logic [31:0]          w_rs_val;
    logic [31:0]          w_rt_val;

    alu_op_e              w_alu_op;
    logic                 w_use_imm;
    logic                 w_reg_we;
    logic [4:0]           w_dest;
    logic                 w_mem_rd;
    logic                 w_mem_wr;
    logic [31:0]          w_alu_b;
    logic [31:0]          w_alu_result;

    logic                 w_io_sel;
    logic [c_DMEM_AW-1:0] w_ram_idx;
    logic [31:0]          w_load;
    logic [31:0]          w_wb_data;

    logic [31:0]          w_pc4;
    logic [31:0]          w_br_target;
    logic [31:0]          w_j_target;
    logic [31:0]          w_pc_next;
    logic                 w_unused;

    // ---------------- Program ROM ----------------
    assign w_iaddr = r_pc[c_IMEM_AW+1:2];

    always_comb begin
        w_instr = 32'h0000_0000;
        case (32'(w_iaddr))
            32'd0:   w_instr = 32'h8C01_0080;  // lw  $1, 0x80($0)
            32'd1:   w_instr = 32'h8C02_0084;  // lw  $2, 0x84($0)
            32'd2:   w_instr = 32'h0022_1820;  // add $3, $1, $2
            32'd3:   w_instr = 32'hAC01_0080;  // sw  $1, 0x80($0)
            32'd4:   w_instr = 32'hAC02_0084;  // sw  $2, 0x84($0)
            32'd5:   w_instr = 32'hAC03_0088;  // sw  $3, 0x88($0)
            32'd6:   w_instr = 32'h0800_0000;  // j   0
            default: w_instr = 32'h0000_0000;
        endcase
    end

    // ---------------- Decode ----------------
    assign w_opcode   = w_instr[31:26];
    assign w_rs       = w_instr[25:21];
    assign w_rt       = w_instr[20:16];
    assign w_rd       = w_instr[15:11];
    assign w_funct    = w_instr[5:0];
    assign w_target   = w_instr[25:0];
    assign w_imm_sext = {{16{w_instr[15]}}, w_instr[15:0]};

    // $0 is never written, so it always reads back its reset value of zero
    assign w_rs_val = r_gpr[w_rs];
    assign w_rt_val = r_gpr[w_rt];

    always_comb begin
        w_alu_op  = ALU_ADD;
        w_use_imm = 1'b0;
        w_reg_we  = 1'b0;
        w_dest    = w_rd;
        w_mem_rd  = 1'b0;
        w_mem_wr  = 1'b0;
        case (w_opcode)
            c_OP_RTYPE: begin
                w_reg_we = 1'b1;
                case (w_funct)
                    c_FN_ADD: w_alu_op = ALU_ADD;
                    c_FN_SUB: w_alu_op = ALU_SUB;
                    c_FN_AND: w_alu_op = ALU_AND;
                    c_FN_OR:  w_alu_op = ALU_OR;
                    c_FN_SLT: w_alu_op = ALU_SLT;
                    default:  w_reg_we = 1'b0;
                endcase
            end
            c_OP_ADDI: begin
                w_use_imm = 1'b1;
                w_reg_we  = 1'b1;
                w_dest    = w_rt;
            end
            c_OP_LW: begin
                w_use_imm = 1'b1;
                w_reg_we  = 1'b1;
                w_dest    = w_rt;
                w_mem_rd  = 1'b1;
            end
            c_OP_SW: begin
                w_use_imm = 1'b1;
                w_mem_wr  = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- ALU ----------------
    assign w_alu_b = w_use_imm ? w_imm_sext : w_rt_val;

    always_comb begin
        w_alu_result = w_rs_val + w_alu_b;
        case (w_alu_op)
            ALU_ADD: w_alu_result = w_rs_val + w_alu_b;
            ALU_SUB: w_alu_result = w_rs_val - w_alu_b;
            ALU_AND: w_alu_result = w_rs_val & w_alu_b;
            ALU_OR:  w_alu_result = w_rs_val | w_alu_b;
            ALU_SLT: w_alu_result = {31'd0, $signed(w_rs_val) < $signed(w_alu_b)};
            default: w_alu_result = w_rs_val + w_alu_b;
        endcase
    end

    // ---------------- Load path: RAM or I/O ----------------
    assign w_io_sel  = w_alu_result[7];
    assign w_ram_idx = w_alu_result[c_DMEM_AW+1:2];

    always_comb begin
        w_load = r_dmem[w_ram_idx];
        if (w_io_sel) begin
            if (w_alu_result[7:2] == c_IO_IN0[7:2]) begin
                w_load = in_port0;
            end else if (w_alu_result[7:2] == c_IO_IN1[7:2]) begin
                w_load = in_port1;
            end else begin
                w_load = 32'd0;
            end
        end
    end

    assign w_wb_data = w_mem_rd ? w_load : w_alu_result;

    // ---------------- Next PC ----------------
    assign w_pc4       = r_pc + 32'd4;
    assign w_br_target = w_pc4 + {w_imm_sext[29:0], 2'b00};
    assign w_j_target  = {w_pc4[31:28], w_target, 2'b00};

    always_comb begin
        w_pc_next = w_pc4;
        case (w_opcode)
            c_OP_BEQ: w_pc_next = (w_rs_val == w_rt_val) ? w_br_target : w_pc4;
            c_OP_BNE: w_pc_next = (w_rs_val != w_rt_val) ? w_br_target : w_pc4;
            c_OP_J:   w_pc_next = w_j_target;
            default:  w_pc_next = w_pc4;
        endcase
    end

    // ---------------- Architectural state ----------------
    always_ff @(posedge mem_clk) begin
        if (resetn) begin
            r_pc   <= 32'd0;
            r_out0 <= 32'd0;
            r_out1 <= 32'd0;
            r_out2 <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                r_gpr[i] <= 32'd0;
            end
        end else begin
            r_pc <= w_pc_next;
            if (w_reg_we && (w_dest != 5'd0)) begin
                r_gpr[w_dest] <= w_wb_data;
            end
            if (w_mem_wr && w_io_sel) begin
                if (w_alu_result[7:2] == c_IO_OUT0[7:2]) begin
                    r_out0 <= w_rt_val;
                end else if (w_alu_result[7:2] == c_IO_OUT1[7:2]) begin
                    r_out1 <= w_rt_val;
                end else if (w_alu_result[7:2] == c_IO_OUT2[7:2]) begin
                    r_out2 <= w_rt_val;
                end
            end
        end
    end

    // Data RAM keeps its contents through reset
    always_ff @(posedge mem_clk) begin
        if (!resetn && w_mem_wr && !w_io_sel) begin
            r_dmem[w_ram_idx] <= w_rt_val;
        end
    end

    assign out_port0 = r_out0;
    assign out_port1 = r_out1;
    assign out_port2 = r_out2;

    // ---------------- Displays ----------------
    dec2seg u_seg_out0 (.i_value(r_out0), .o_tens(hex5), .o_ones(hex4));
    dec2seg u_seg_out1 (.i_value(r_out1), .o_tens(hex3), .o_ones(hex2));
    dec2seg u_seg_out2 (.i_value(r_out2), .o_tens(hex1), .o_ones(hex0));

    assign w_unused = ^{w_instr[10:6], w_alu_result[31:8], w_alu_result[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_sc_computer_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_sc_computer_top
// Description : Self-checking bench for sc_computer_top against a program-level
//               model of the built-in copy/add loop.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sc_computer_top;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [31:0] in_port0 = 32'd0;
    logic [31:0] in_port1 = 32'd0;
    logic [31:0] out_port0, out_port1, out_port2;
    logic [6:0]  hex5, hex4, hex3, hex2, hex1, hex0;

    int n_tests = 0;
    int n_fails = 0;

    sc_computer_top #(.IMEM_WORDS(64), .DMEM_WORDS(32)) dut (
        .mem_clk  (clk),
        .resetn   (resetn),
        .in_port0 (in_port0),
        .in_port1 (in_port1),
        .out_port0(out_port0),
        .out_port1(out_port1),
        .out_port2(out_port2),
        .hex5     (hex5),
        .hex4     (hex4),
        .hex3     (hex3),
        .hex2     (hex2),
        .hex1     (hex1),
        .hex0     (hex0)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] tens_of(input logic [31:0] v);
        return seg(int'((v % 32'd100) / 32'd10));
    endfunction

    function automatic logic [6:0] ones_of(input logic [31:0] v);
        return seg(int'(v % 32'd10));
    endfunction

    // Program-level model: position within the 7-instruction loop and the
    // values the program has latched so far.
    int          m_step  = 0;
    bit          m_valid = 1'b0;
    logic [31:0] m_a, m_b, m_sum;
    logic [31:0] m_out0, m_out1, m_out2;

    always @(posedge clk) begin
        if (resetn) begin
            m_step  = 0;
            m_valid = 1'b1;
            m_a = 0; m_b = 0; m_sum = 0;
            m_out0 = 0; m_out1 = 0; m_out2 = 0;
        end else if (m_valid) begin
            case (m_step)
                0: m_a    = in_port0;
                1: m_b    = in_port1;
                2: m_sum  = m_a + m_b;
                3: m_out0 = m_a;
                4: m_out1 = m_b;
                5: m_out2 = m_sum;
                default: ;
            endcase
            m_step = (m_step + 1) % 7;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("out_port0", out_port0, m_out0);
            check("out_port1", out_port1, m_out1);
            check("out_port2", out_port2, m_out2);
            check("hex5", {25'd0, hex5}, {25'd0, tens_of(m_out0)});
            check("hex4", {25'd0, hex4}, {25'd0, ones_of(m_out0)});
            check("hex3", {25'd0, hex3}, {25'd0, tens_of(m_out1)});
            check("hex2", {25'd0, hex2}, {25'd0, ones_of(m_out1)});
            check("hex1", {25'd0, hex1}, {25'd0, tens_of(m_out2)});
            check("hex0", {25'd0, hex0}, {25'd0, ones_of(m_out2)});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset held: outputs zero, every display "0", PC parked at 0
        resetn = 1'b1; in_port0 = 32'd9; in_port1 = 32'd3;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("reset_pc", dut.r_pc, 32'd0);
        end
        check("reset_out0", out_port0, 32'd0);
        check("reset_out2", out_port2, 32'd0);
        check("reset_hex5", {25'd0, hex5}, {25'd0, 7'b1000000});
        check("reset_hex0", {25'd0, hex0}, {25'd0, 7'b1000000});

        // Release: out0 at edge 4, out1 at edge 5, out2 at edge 6
        resetn = 1'b0;
        tick(3);
        check("lat_out0_e3", out_port0, 32'd0);
        tick(1);
        check("lat_out0_e4", out_port0, 32'd9);
        check("lat_out1_e4", out_port1, 32'd0);
        tick(1);
        check("lat_out1_e5", out_port1, 32'd3);
        check("lat_out2_e5", out_port2, 32'd0);
        tick(1);
        check("lat_out2_e6", out_port2, 32'd12);
        check("hex5_0", {25'd0, hex5}, {25'd0, 7'b1000000});
        check("hex4_9", {25'd0, hex4}, {25'd0, 7'b0010000});
        check("hex3_0", {25'd0, hex3}, {25'd0, 7'b1000000});
        check("hex2_3", {25'd0, hex2}, {25'd0, 7'b0110000});
        check("hex1_1", {25'd0, hex1}, {25'd0, 7'b1111001});
        check("hex0_2", {25'd0, hex0}, {25'd0, 7'b0100100});

        // Input change just after instruction 0 of the second iteration (edge 8)
        tick(2);
        in_port0 = 32'd20;
        tick(3);
        check("midloop_out0_e11", out_port0, 32'd9);
        tick(2);
        check("midloop_out2_e13", out_port2, 32'd12);
        tick(5);
        check("next_iter_out0_e18", out_port0, 32'd20);
        tick(2);
        check("next_iter_out2_e20", out_port2, 32'd23);

        // Sum rolling past 99 and 32-bit wrap
        in_port0 = 32'd60; in_port1 = 32'd55;
        tick(14);
        check("sum_115", out_port2, 32'd115);
        check("hex1_115", {25'd0, hex1}, {25'd0, 7'b1111001});
        check("hex0_115", {25'd0, hex0}, {25'd0, 7'b0010010});
        in_port0 = 32'hFFFF_FFFF; in_port1 = 32'd1;
        tick(14);
        check("sum_wrap", out_port2, 32'd0);
        check("hex5_ffff", {25'd0, hex5}, {25'd0, 7'b0010000});
        check("hex4_ffff", {25'd0, hex4}, {25'd0, 7'b0010010});

        // One-edge reset mid-loop, then the same latencies from PC=0
        in_port0 = 32'd7; in_port1 = 32'd8;
        tick(3);
        resetn = 1'b1;
        tick(1);
        check("midreset_out0", out_port0, 32'd0);
        check("midreset_out2", out_port2, 32'd0);
        resetn = 1'b0;
        tick(4);
        check("restart_out0_e4", out_port0, 32'd7);
        check("restart_out1_e4", out_port1, 32'd0);
        tick(2);
        check("restart_out2_e6", out_port2, 32'd15);

        // Decimal sweep of port 0
        in_port1 = 32'd0;
        for (int v = 0; v < 100; v++) begin
            in_port0 = 32'(v);
            tick(14);
            check("sweep_hex5", {25'd0, hex5}, {25'd0, seg(v / 10)});
            check("sweep_hex4", {25'd0, hex4}, {25'd0, seg(v % 10)});
        end

        // Random inputs, random hold times, occasional reset pulses
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                in_port0 = $urandom;
                in_port1 = $urandom;
            end else begin
                in_port0 = 32'($urandom_range(0, 99));
                in_port1 = 32'($urandom_range(0, 99));
            end
            if ($urandom_range(0, 19) == 0) begin
                resetn = 1'b1;
                tick(1);
                resetn = 1'b0;
            end
            tick(int'($urandom_range(1, 20)));
        end

        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
